// File: rtl/lifo_stack_if.sv
// Handshake bundle for the LIFO stack.
// Carries the optional almost_full pin when LIFO_STACK_WATERMARK_EN is set.
interface lifo_stack_if #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             clear;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [WIDTH-1:0] top_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
`ifdef LIFO_STACK_WATERMARK_EN
  logic             almost_full;
`endif

  modport master (
    output clear, push, pop, data_in,
    input  data_out, data_valid, top_data,
    input  count, empty, full, overflow, underflow
`ifdef LIFO_STACK_WATERMARK_EN
    , input almost_full
`endif
  );

  modport slave (
    input  clear, push, pop, data_in,
    output data_out, data_valid, top_data,
    output count, empty, full, overflow, underflow
`ifdef LIFO_STACK_WATERMARK_EN
    , output almost_full
`endif
  );
endinterface

// File: rtl/lifo_stack.sv
// Parametrised LIFO with peek, replace, clear and sticky error flags.
// Optional watermark output under LIFO_STACK_WATERMARK_EN.
module lifo_stack #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256
`ifdef LIFO_STACK_WATERMARK_EN
  , parameter int AF_LEVEL = DEPTH - 1
`endif
) (
  input logic        clk,
  input logic        rst_n,
  lifo_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DMAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nx;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             wr_en;
  logic             pop_ok;
  logic             ovf_set;
  logic             unf_set;
  logic             empty;
  logic             full;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             overflow;
  logic             underflow;

  assign empty   = (count == '0);
  assign full    = (count == DMAX);
  assign top_idx = empty ? '0 : AW'(count - 1'b1);

  // decide this edge's write, pop and next count
  always_comb begin
    count_nx = count;
    wr_en    = 1'b0;
    wr_idx   = AW'(count);
    pop_ok   = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (bus.clear) begin
      count_nx = '0;
    end else if (bus.push && bus.pop) begin
      if (!empty) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
        pop_ok = 1'b1;
      end else begin
        wr_en    = 1'b1;
        count_nx = count + 1'b1;
        unf_set  = 1'b1;
      end
    end else if (bus.push) begin
      if (!full) begin
        wr_en    = 1'b1;
        count_nx = count + 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (bus.pop) begin
      if (!empty) begin
        pop_ok   = 1'b1;
        count_nx = count - 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end
  end

  // storage is left unreset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= bus.data_in;
  end

  // count, pop data and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (bus.clear) begin
      count      <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      count      <= count_nx;
      data_valid <= pop_ok;
      if (pop_ok) data_out <= mem[top_idx];
      if (ovf_set) overflow <= 1'b1;
      if (unf_set) underflow <= 1'b1;
    end
  end

`ifdef LIFO_STACK_WATERMARK_EN
  localparam logic [CW-1:0] AF = CW'(AF_LEVEL);
  logic almost_full;

  // watermark tracks the count being loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) almost_full <= 1'b0;
    else        almost_full <= (count_nx >= AF);
  end

  assign bus.almost_full = almost_full;
`endif

  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.top_data   = empty ? '0 : mem[top_idx];
  assign bus.count      = count;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.overflow   = overflow;
  assign bus.underflow  = underflow;
endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised synchronous LIFO; next generation of the direction stack used by the maze-walker datapath for backtracking.
- Generalised in data width and depth.
- Adds full/count status, combinational peek, same-cycle push+pop (replace), synchronous clear, sticky overflow/underflow flags and a registered pop-data valid strobe.

Parameters:
- WIDTH, 2, data word width in bits (2 = one maze direction); legal range >= 1.
- DEPTH, 256, number of entries; legal range >= 2, power of two not required.
- CW, $clog2(DEPTH)+1, width of count (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; highest priority after reset.
- push  in  1  write data_in onto top.
- pop  in  1  remove top entry.
- data_in  in  WIDTH  word to push.
- data_out  out  WIDTH  registered word popped in previous cycle.
- data_valid  out  1  one-cycle strobe: data_out updated by an accepted pop.
- top_data  out  WIDTH  combinational peek of current top; 0 when empty.
- count  out  CW  current number of stored entries (registered).
- empty  out  1  count == 0 (combinational from count).
- full  out  1  count == DEPTH (combinational from count).
- overflow  out  1  sticky: push rejected while full.
- underflow  out  1  sticky: pop rejected while empty.

Behaviour:
- Reset (rst_n low, asynchronous): count=0, data_out=0, data_valid=0, overflow=0, underflow=0. Storage array is not reset. Outputs therefore read empty=1, full=0, top_data=0.
- Release of rst_n is synchronised externally; the first edge after release is a normal cycle.
- Priority per edge: clear > push/pop. clear: count=0, overflow=0, underflow=0, data_valid=0, data_out holds. push/pop on a clear cycle are ignored.
- Push only, not full: mem[count] <= data_in; count+1. Visible on top_data next cycle.
- Push only, full: write dropped, count unchanged, overflow <= 1.
- Pop only, not empty: data_out <= mem[count-1]; data_valid <= 1 next cycle; count-1.
- Pop only, empty: count unchanged, data_out holds, data_valid <= 0, underflow <= 1.
- Push+pop, not empty (including full): replace.
  - data_out <= old top; data_valid <= 1.
  - mem[count-1] <= data_in; count unchanged.
  - No overflow is flagged.
- Push+pop, empty: push accepted (count becomes 1); pop rejected, underflow <= 1, data_valid <= 0.
- Idle cycle: data_valid <= 0; everything else holds.
- Pop latency: 1 cycle (pop sampled at edge N, data_out/data_valid valid after edge N).
- Flags are cleared only by reset or clear.
- count never exceeds DEPTH and never wraps below 0. Pointer arithmetic is done at CW bits, so DEPTH = 2^k+1 etc. is legal.
- Inputs with X on push/pop are a bench error; no special handling.

Optional Feature:
- Macro: LIFO_STACK_WATERMARK_EN.
- Defined:
  - Adds parameter AF_LEVEL (default DEPTH-1).
  - Adds output almost_full (1 bit), registered, equal to (next count >= AF_LEVEL). It is updated on the same edge as count and reset to 0.
- Undefined: parameter and port are absent; behaviour otherwise identical.

Test Plan (WIDTH=2, DEPTH=4):
- Reset then push 1,2,3 -> count=3, top_data=3, empty=0, full=0. Pop x3 -> data_out 3,2,1 on successive cycles, data_valid=1 each cycle. Then empty=1, top_data=0.
- Push 0,1,2,3 then push 2 -> full=1 after 4th push; 5th dropped, overflow=1, count=4, top_data=3.
- From empty, pop -> underflow=1, data_valid=0, data_out unchanged. Then clear -> underflow=0, count=0.
- Stack holds 1,2; push=1,pop=1,data_in=3 -> data_out=2, data_valid=1, count=2, top_data=3. Repeat with full stack holding 0,1,2,3 -> count stays 4, no overflow.
- Push 1,2, assert rst_n low mid-cycle between edges -> count=0, data_valid=0 immediately, without a clock edge.
- With LIFO_STACK_WATERMARK_EN, AF_LEVEL=3: push x3 -> almost_full=1 after 3rd push. Pop x1 -> almost_full=0.
